regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
Write-side driver for the 8-entry, 8-bit register bank, where x0 is hardwired to zero. It merges results from two producers onto the bank's single write port (wd3/we3/wa3):
- the single-cycle ALU, which has no back-pressure;
- the multi-cycle load unit, which uses a valid/ready handshake.

Load results that lose arbitration wait in a small FIFO. A per-register busy scoreboard tracks outstanding loads so the hazard logic can stall.

Parameters:
DW, 8, data width of results and wd3
AW, 3, register address width (2**AW registers)
DEPTH, 2, load FIFO depth; legal range 1..4

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
alu_we  input  1  ALU result valid this cycle
alu_wa  input  AW  ALU destination register
alu_wd  input  DW  ALU result
ld_valid  input  1  load result valid
ld_ready  output  1  FIFO can accept a load result
ld_wa  input  AW  load destination register
ld_wd  input  DW  load data
ld_issue  input  1  load issued to memory this cycle
ld_issue_rd  input  AW  destination of the issued load
we3  output  1  register bank write enable (registered)
wa3  output  AW  register bank write address (registered)
wd3  output  DW  register bank write data (registered)
busy  output  2**AW  per-register outstanding-load flags
fifo_count  output  3  current FIFO occupancy
haz_err  output  1  sticky WAW hazard flag (see Optional Feature)

Behaviour:
Reset (clk edge with rst=0):
- we3=0, wa3=0, wd3=0, busy=0, fifo_count=0, haz_err=0.
- FIFO is emptied.
- Overrides any event in the same cycle, including an in-flight write.

Write port:
- we3/wa3/wd3 are registered: a winner selected in cycle N appears in cycle N+1 for exactly one cycle.
- With no winner, we3=0 and wa3/wd3 hold their last value.

Arbitration each cycle, priority order:
1. ALU write, if alu_we=1 and alu_wa!=0.
2. FIFO head (pop), if FIFO is non-empty.
3. Bypass of the incoming load, if ld_valid&ld_ready, FIFO is empty and ld_wa!=0. The load appears on we3 next cycle and is not enqueued.

Load acceptance:
- ld_ready = (fifo_count < DEPTH), evaluated from registered count only; no same-cycle pop credit.
- An accepted load that is not bypassed is pushed to the FIFO tail.
- Push and pop in the same cycle leave the count unchanged.
- Accepted loads with ld_wa==0 are consumed and discarded: never enqueued, never written.

Order and starvation:
- FIFO order is strict FIFO; loads are never reordered among themselves.
- Continuous ALU writes starve loads. ld_ready falls once the FIFO is full; this is legal behaviour.

x0 protection:
- we3 is never asserted with wa3==0.
- ALU writes to x0 are dropped.

Scoreboard:
- ld_issue=1 with ld_issue_rd!=0 sets busy[ld_issue_rd] at the next edge.
- A load-sourced write (popped or bypassed) clears busy[wa] at the same edge that registers we3.
- If a set and a clear hit the same register in the same cycle, set wins.
- busy[0] is always 0.
- ALU writes never change busy.

Optional Feature:
Macro: WB_HAZARD_CHECK_EN.
- Defined: haz_err is set, sticky until reset, when an ALU write is selected (alu_we=1, alu_wa!=0) while busy[alu_wa]=1. This is a WAW hazard that the upstream stall logic should have prevented. The write itself still proceeds.
- Not defined: haz_err is driven constant 0 and no compare logic is built. The port is present in both builds.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with alu_we=1, ld_valid=1 -> we3=0, wa3=0, wd3=0, busy=0, fifo_count=0, ld_ready=1 after the release edge.
2. ALU write: cycle N alu_we=1, alu_wa=3, alu_wd=0x5A -> N+1 we3=1, wa3=3, wd3=0x5A; N+2 we3=0.
3. Collision: cycle N ALU (wa=2, 0x11) plus load (wa=4, 0x22) -> N+1 writes r2=0x11; N+2 writes r4=0x22; fifo_count 1 then 0.
4. FIFO full: ALU writes 4 consecutive cycles while loads 0xA1, 0xA2, 0xA3 are offered -> 0xA1 and 0xA2 accepted, ld_ready=0 at fifo_count=2. After the ALU stops, 0xA1 is written before 0xA2, then 0xA3 is accepted.
5. x0: alu_wa=0 -> we3 stays 0; load with ld_wa=0 -> accepted (ld_ready=1), no write, fifo_count unchanged.
6. Scoreboard: ld_issue rd=5 -> busy[5]=1 next cycle; load writeback to r5 -> busy[5]=0 on the edge where we3=1. With WB_HAZARD_CHECK_EN, an ALU write to r5 while busy -> haz_err=1, held until rst=0.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side driver for the register bank.
// Merges a single-cycle ALU result (no back-pressure) and a multi-cycle
// load result (valid/ready) onto one registered write port. Loads that lose
// arbitration wait in a small FIFO; a busy scoreboard tracks outstanding loads.
// Optional build macro: WB_HAZARD_CHECK_EN enables the sticky WAW flag haz_err.
module regfile_writeback #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 2   // load FIFO depth, 1..4
) (
  input  logic              clk,
  input  logic              rst,          // synchronous, active low
  input  logic              alu_we,
  input  logic [AW-1:0]     alu_wa,
  input  logic [DW-1:0]     alu_wd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_wa,
  input  logic [DW-1:0]     ld_wd,
  input  logic              ld_issue,
  input  logic [AW-1:0]     ld_issue_rd,
  output logic              we3,
  output logic [AW-1:0]     wa3,
  output logic [DW-1:0]     wd3,
  output logic [2**AW-1:0]  busy,
  output logic [2:0]        fifo_count,
  output logic              haz_err
);

  localparam int NREG = 2**AW;

  // FIFO storage is always four slots deep so the 2-bit pointers index it
  // exactly; only the first DEPTH slots are ever used.
  logic [AW-1:0]   r_fifo_wa [4];
  logic [DW-1:0]   r_fifo_wd [4];
  logic [1:0]      r_rd_ptr, r_wr_ptr;
  logic [2:0]      r_count;

  logic            r_we3;
  logic [AW-1:0]   r_wa3;
  logic [DW-1:0]   r_wd3;
  logic [NREG-1:0] r_busy;

  logic            w_ld_acc, w_alu_sel, w_fifo_nempty;
  logic            w_pop, w_byp, w_push;
  logic            w_win;
  logic [AW-1:0]   w_win_wa;
  logic [DW-1:0]   w_win_wd;
  logic            w_ld_win;
  logic [NREG-1:0] w_set, w_clr;
  logic [1:0]      w_rd_ptr_nxt, w_wr_ptr_nxt;

  // Ready is derived only from the registered count: a pop in the same
  // cycle does not make room for an extra load.
  assign ld_ready      = (r_count < 3'(DEPTH));
  assign w_ld_acc      = ld_valid & ld_ready;
  assign w_alu_sel     = alu_we & (alu_wa != '0);
  assign w_fifo_nempty = (r_count != 3'd0);

  // Priority: ALU, then FIFO head, then bypass of an incoming load.
  assign w_pop  = ~w_alu_sel & w_fifo_nempty;
  assign w_byp  = ~w_alu_sel & ~w_fifo_nempty & w_ld_acc & (ld_wa != '0);
  // Loads to x0 are accepted and silently discarded.
  assign w_push = w_ld_acc & (ld_wa != '0) & ~w_byp;

  assign w_rd_ptr_nxt = (r_rd_ptr == 2'(DEPTH-1)) ? 2'd0 : r_rd_ptr + 2'd1;
  assign w_wr_ptr_nxt = (r_wr_ptr == 2'(DEPTH-1)) ? 2'd0 : r_wr_ptr + 2'd1;

  // Select the winner for the write port this cycle.
  always_comb begin
    w_win    = 1'b0;
    w_ld_win = 1'b0;
    w_win_wa = r_wa3;
    w_win_wd = r_wd3;
    if (w_alu_sel) begin
      w_win    = 1'b1;
      w_win_wa = alu_wa;
      w_win_wd = alu_wd;
    end else if (w_pop) begin
      w_win    = 1'b1;
      w_ld_win = 1'b1;
      w_win_wa = r_fifo_wa[r_rd_ptr];
      w_win_wd = r_fifo_wd[r_rd_ptr];
    end else if (w_byp) begin
      w_win    = 1'b1;
      w_ld_win = 1'b1;
      w_win_wa = ld_wa;
      w_win_wd = ld_wd;
    end
  end

  // Scoreboard set/clear masks; x0 is never tracked.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (ld_issue && ld_issue_rd != '0) w_set = NREG'(1) << ld_issue_rd;
    if (w_ld_win)                      w_clr = NREG'(1) << w_win_wa;
  end

  // FIFO payload storage; contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wa[r_wr_ptr] <= ld_wa;
      r_fifo_wd[r_wr_ptr] <= ld_wd;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port: a winner shows for exactly one cycle; address
  // and data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we3 <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
    end else begin
      r_we3 <= w_win;
      if (w_win) begin
        r_wa3 <= w_win_wa;
        r_wd3 <= w_win_wd;
      end
    end
  end

  // Busy scoreboard: set beats clear on the same register; bit 0 stays low.
  always_ff @(posedge clk) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREG'(1);
  end

`ifdef WB_HAZARD_CHECK_EN
  logic r_haz_err;

  // Sticky WAW flag: ALU writes a register that still has a load in flight.
  always_ff @(posedge clk) begin
    if (!rst)                             r_haz_err <= 1'b0;
    else if (w_alu_sel && r_busy[alu_wa]) r_haz_err <= 1'b1;
  end

  assign haz_err = r_haz_err;
`else
  assign haz_err = 1'b0;
`endif

  assign we3        = r_we3;
  assign wa3        = r_wa3;
  assign wd3        = r_wd3;
  assign busy       = r_busy;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios followed by random traffic,
// all predicted by a queue-based behavioural model of the write-back rules.
module tb_regfile_writeback;
  localparam int DW = 8, AW = 3, DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_we, ld_valid, ld_issue;
  logic [AW-1:0] alu_wa, ld_wa, ld_issue_rd;
  logic [DW-1:0] alu_wd, ld_wd;
  logic          ld_ready, we3, haz_err;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [7:0]    busy;
  logic [2:0]    fifo_count;

  regfile_writeback #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .busy(busy), .fifo_count(fifo_count), .haz_err(haz_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: pending loads as a queue of {addr,data}.
  typedef struct { logic [AW-1:0] wa; logic [DW-1:0] wd; } ld_t;
  ld_t           q[$];
  logic [7:0]    m_busy = '0;
  logic          m_we = 1'b0, m_haz = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;

  task automatic step(input logic r, input logic awe, input logic [AW-1:0] awa,
                      input logic [DW-1:0] awd, input logic lv, input logic [AW-1:0] lwa,
                      input logic [DW-1:0] lwd, input logic iss, input logic [AW-1:0] ird);
    logic acc, byp, win;
    logic [7:0] nb;
    ld_t e;
    @(negedge clk);
    rst = r; alu_we = awe; alu_wa = awa; alu_wd = awd;
    ld_valid = lv; ld_wa = lwa; ld_wd = lwd; ld_issue = iss; ld_issue_rd = ird;
    #1;
    chk("ld_ready", ld_ready, (q.size() < DEPTH));
    if (!r) begin
      q.delete(); m_busy = '0; m_we = 0; m_wa = '0; m_wd = '0; m_haz = 0;
    end else begin
      acc = lv && (q.size() < DEPTH);
      byp = 0; win = 0; nb = m_busy;
      if (awe && awa != 0) begin
        win = 1; m_wa = awa; m_wd = awd;
`ifdef WB_HAZARD_CHECK_EN
        if (m_busy[awa]) m_haz = 1;
`endif
      end else if (q.size() > 0) begin
        e = q.pop_front();
        win = 1; m_wa = e.wa; m_wd = e.wd; nb[e.wa] = 0;
      end else if (acc && lwa != 0) begin
        byp = 1; win = 1; m_wa = lwa; m_wd = lwd; nb[lwa] = 0;
      end
      if (acc && lwa != 0 && !byp) begin
        e.wa = lwa; e.wd = lwd; q.push_back(e);
      end
      if (iss && ird != 0) nb[ird] = 1;
      nb[0] = 0;
      m_busy = nb; m_we = win;
    end
    @(posedge clk); #1;
    chk("we3", we3, m_we);
    chk("wa3", wa3, m_wa);
    chk("wd3", wd3, m_wd);
    chk("busy", busy, m_busy);
    chk("fifo_count", fifo_count, q.size());
    chk("haz_err", haz_err, m_haz);
    if (we3) chk("we3_x0", (wa3 == 0), 0);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 0; alu_we = 0; alu_wa = 0; alu_wd = 0; ld_valid = 0; ld_wa = 0;
    ld_wd = 0; ld_issue = 0; ld_issue_rd = 0;
    // Reset held with traffic present; everything must come up cleared.
    step(0, 1, 3, 8'h77, 1, 4, 8'h66, 1, 2);
    step(0, 1, 3, 8'h77, 1, 4, 8'h66, 1, 2);
    chk("rst_we3", we3, 0); chk("rst_busy", busy, 0); chk("rst_cnt", fifo_count, 0);
    idle();
    chk("rst_ready", ld_ready, 1);

    // Plain ALU write, then idle.
    step(1, 1, 3, 8'h5A, 0, 0, 0, 0, 0);
    chk("alu_wd3", wd3, 8'h5A); chk("alu_wa3", wa3, 3);
    idle();
    chk("alu_we3_off", we3, 0);

    // ALU and load collide: ALU first, load one cycle later from the FIFO.
    step(1, 1, 2, 8'h11, 1, 4, 8'h22, 0, 0);
    chk("col_cnt1", fifo_count, 1);
    idle();
    chk("col_wd3", wd3, 8'h22); chk("col_cnt0", fifo_count, 0);

    // FIFO fills under continuous ALU writes, then drains in order.
    step(1, 1, 1, 8'h01, 1, 6, 8'hA1, 0, 0);
    step(1, 1, 1, 8'h02, 1, 6, 8'hA2, 0, 0);
    step(1, 1, 1, 8'h03, 1, 7, 8'hA3, 0, 0);
    chk("full_ready", ld_ready, 0);
    step(1, 1, 1, 8'h04, 1, 7, 8'hA3, 0, 0);
    step(1, 0, 0, 0, 1, 7, 8'hA3, 0, 0);
    chk("drain_a1", wd3, 8'hA1);
    step(1, 0, 0, 0, 1, 7, 8'hA3, 0, 0);
    chk("drain_a2", wd3, 8'hA2);
    idle();
    chk("drain_a3", wd3, 8'hA3);

    // x0 protection on both sources.
    step(1, 1, 0, 8'hEE, 0, 0, 0, 0, 0);
    chk("x0_alu", we3, 0);
    step(1, 0, 0, 0, 1, 0, 8'hDD, 0, 0);
    chk("x0_ld", we3, 0); chk("x0_cnt", fifo_count, 0);

    // Scoreboard set, clear on load writeback, and the hazard case.
    step(1, 0, 0, 0, 0, 0, 0, 1, 5);
    chk("sb_set", busy[5], 1);
    step(1, 1, 5, 8'h55, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 5, 8'h99, 0, 0);
    chk("sb_clr", busy[5], 0); chk("sb_we", we3, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("sb_x0", busy[0], 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 1) == 1), AW'($urandom), DW'($urandom),
           ($urandom_range(0, 1) == 1), AW'($urandom), DW'($urandom),
           ($urandom_range(0, 3) == 0), AW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
